// File: rtl/disp_pkg.sv
// disp_pkg: shared types, font and helpers for the display scheduler
package disp_pkg;
  typedef enum logic [1:0] {ARB, CONVERT, SHOW} state_t;
  localparam int SCAN_DIV_DEF = 100_000;
  localparam logic [6:0] HEX_FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  function automatic logic [3:0] add3(input logic [3:0] n);
    return n >= 4'd5 ? n + 4'd3 : n;
  endfunction
endpackage

// File: rtl/disp_sched_bin2bcd.sv
// bin2bcd_seq: 8-cycle shift-add-3 binary to BCD converter, done pulses after the last iteration
module bin2bcd_seq
  import disp_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] bin,
  output logic       done,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] ones
);
  logic [19:0] sh, nxt;
  logic [2:0] cnt;
  logic busy;
  assign nxt = {add3(sh[19:16]), add3(sh[15:12]), add3(sh[11:8]), sh[7:0]} << 1;
  // load on start, iterate while busy, latch digits on the eighth step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh <= '0;
      cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      hundreds <= '0;
      tens <= '0;
      ones <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        sh <= {12'd0, bin};
        cnt <= '0;
        busy <= 1'b1;
      end else if (busy) begin
        sh <= nxt;
        cnt <= cnt + 3'd1;
        if (cnt == 3'd7) begin
          busy <= 1'b0;
          done <= 1'b1;
          hundreds <= nxt[19:16];
          tens <= nxt[15:12];
          ones <= nxt[11:8];
        end
      end
    end
  end
endmodule

// File: rtl/disp_sched.sv
// disp_sched: round-robin sharing of a 4-digit seven-segment display (DISP_SRC_DIGIT_EN shows src_id on the thousands digit)
module disp_sched
  import disp_pkg::*;
#(
  parameter int N_SRC       = 4,
  parameter int SCAN_DIV    = SCAN_DIV_DEF,
  parameter int DWELL_TICKS = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_SRC-1:0]   req,
  input  logic [8*N_SRC-1:0] data,
  output logic [N_SRC-1:0]   grant,
  output logic [2:0]         src_id,
  output logic               bcd_valid,
  output logic [6:0]         seg,
  output logic [3:0]         an
);
  localparam int CW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int DW = $clog2(DWELL_TICKS + 1);
  state_t state, nxt_state;
  logic [CW-1:0] scnt;
  logic tick;
  logic [1:0] digit_sel;
  logic [2:0] rr_ptr, win;
  logic [3:0] p, sum;
  logic [N_SRC-1:0] rq2;
  logic found, start, done, rel;
  logic [7:0] cap;
  logic [DW-1:0] dwell;
  logic [3:0] hund, tens, ones, thou, digit;
  assign tick = scnt == CW'(SCAN_DIV - 1);
  assign found = |req;
  assign start = state == ARB && found;
  assign rel = state == SHOW && (dwell == DW'(DWELL_TICKS) || !(|(req & grant)));
  bin2bcd_seq u_conv (
    .clk(clk), .rst(rst), .start(start), .bin(cap),
    .done(done), .hundreds(hund), .tens(tens), .ones(ones)
  );
  // free-running scan timebase and digit selector
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scnt <= '0;
      digit_sel <= '0;
    end else begin
      scnt <= tick ? '0 : scnt + 1'b1;
      digit_sel <= digit_sel + {1'b0, tick};
    end
  end
  // rotate requests by rr_ptr, pick the first set bit and select its data
  always_comb begin
    rq2 = N_SRC'({req, req} >> rr_ptr);
    p = '0;
    for (int i = N_SRC - 1; i >= 0; i--) if (rq2[i]) p = 4'(i);
    sum = {1'b0, rr_ptr} + p;
    win = sum >= 4'(N_SRC) ? 3'(sum - 4'(N_SRC)) : sum[2:0];
    cap = '0;
    for (int i = 0; i < N_SRC; i++) if (3'(i) == win) cap = data[8*i +: 8];
  end
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ARB;
    else state <= nxt_state;
  end
  // next-state logic
  always_comb begin
    nxt_state = state == ARB ? (found ? CONVERT : ARB) :
                state == CONVERT ? (done ? SHOW : CONVERT) :
                (rel ? ARB : SHOW);
  end
  // grant bookkeeping and dwell timer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_id <= '0;
      rr_ptr <= '0;
      dwell <= '0;
    end else begin
      if (start) begin
        src_id <= win;
        rr_ptr <= win == 3'(N_SRC - 1) ? '0 : win + 3'd1;
      end
      dwell <= state == SHOW ? dwell + DW'(tick) : '0;
    end
  end
  // outputs decoded from state, owner and scan position
  always_comb begin
    grant = state != ARB ? N_SRC'(1) << src_id : '0;
    bcd_valid = state == SHOW;
`ifdef DISP_SRC_DIGIT_EN
    thou = {1'b0, src_id};
`else
    thou = 4'd0;
`endif
    digit = digit_sel == 2'd0 ? ones : digit_sel == 2'd1 ? tens : digit_sel == 2'd2 ? hund : thou;
    an = state == SHOW ? ~(4'b0001 << digit_sel) : 4'hF;
    seg = state == SHOW ? HEX_FONT[digit] : 7'h7F;
  end
endmodule

// File: tb/tb_disp_sched.sv
// tb_disp_sched: scoreboard bench for disp_sched with directed vectors
module tb_disp_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req = '0;
  logic [31:0] data = '0;
  logic [3:0] grant;
  logic [2:0] src_id;
  logic bcd_valid;
  logic [6:0] seg;
  logic [3:0] an;
  typedef struct packed {
    logic [3:0]  grant;
    logic [27:0] segs;
  } exp_t;
  exp_t sb[$];
  int nvec = 0;
  int nerr = 0;
  localparam logic [6:0] FONT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  always #5 clk = ~clk;
  disp_sched #(.N_SRC(4), .SCAN_DIV(4), .DWELL_TICKS(3)) dut (
    .clk(clk), .rst(rst), .req(req), .data(data), .grant(grant),
    .src_id(src_id), .bcd_valid(bcd_valid), .seg(seg), .an(an)
  );
  function automatic exp_t mk(int k, int v);
    exp_t e;
    int th;
    th = 0;
`ifdef DISP_SRC_DIGIT_EN
    th = k;
`endif
    e.grant = 4'(1 << k);
    e.segs = {FONT[th], FONT[v / 100], FONT[(v / 10) % 10], FONT[v % 10]};
    return e;
  endfunction
  task automatic chk(string nm, int act, int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic wait_valid(logic lvl);
    int n;
    n = 0;
    @(negedge clk);
    while (bcd_valid !== lvl && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("wait_valid", int'(bcd_valid), int'(lvl));
  endtask
  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    req = '0;
    @(posedge clk);
    #2 rst = 1'b0;
  endtask
  // monitor: pops an expectation on each bcd_valid rise, checks every displayed digit
  initial begin
    logic [3:0] pg;
    logic pv;
    int gcnt, d;
    exp_t cur;
    pg = '0;
    pv = 1'b0;
    gcnt = 0;
    cur = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pg = '0;
        pv = 1'b0;
      end else begin
        gcnt = (grant != 0 && pg == 0) ? 0 : gcnt + 1;
        if (bcd_valid && !pv) begin
          chk("sb_pending", int'(sb.size() != 0), 1);
          if (sb.size() != 0) begin
            cur = sb.pop_front();
            chk("grant", grant, cur.grant);
            chk("latency", gcnt, 9);
          end
        end
        if (bcd_valid) begin
          d = an == 4'hE ? 0 : an == 4'hD ? 1 : an == 4'hB ? 2 : an == 4'h7 ? 3 : -1;
          chk("an_onehot", int'(d >= 0), 1);
          if (d >= 0) chk($sformatf("seg%0d", d), seg, cur.segs[7*d +: 7]);
        end
        pg = grant;
        pv = bcd_valid;
      end
    end
  end
  // stimulus
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_seg", seg, 7'h7F);
    chk("rst_an", an, 4'hF);
    chk("rst_grant", grant, 0);
    chk("rst_valid", bcd_valid, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    data[7:0] = 8'd173;
    sb.push_back(mk(0, 173));
    sb.push_back(mk(0, 173));
    @(posedge clk);
    #2 req = 4'b0001;
    wait_valid(1'b1);
    wait_valid(1'b0);
    chk("release_grant", grant, 0);
    @(negedge clk);
    chk("regrant", grant, 4'b0001);
    req = '0;
    wait_valid(1'b1);
    wait_valid(1'b0);
    do_reset();
    data = {8'd99, 8'd0, 8'd200, 8'd5};
    sb.push_back(mk(0, 5));
    sb.push_back(mk(1, 200));
    sb.push_back(mk(3, 99));
    sb.push_back(mk(0, 5));
    @(posedge clk);
    #2 req = 4'b1011;
    repeat (3) begin
      wait_valid(1'b1);
      wait_valid(1'b0);
    end
    wait_valid(1'b1);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midshow_rst_seg", seg, 7'h7F);
    chk("midshow_rst_an", an, 4'hF);
    chk("midshow_rst_grant", grant, 0);
    chk("midshow_rst_valid", bcd_valid, 0);
    req = '0;
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      chk("idle", {grant, an, bcd_valid}, {4'h0, 4'hF, 1'b0});
    end
    do_reset();
    data = {16'd0, 8'd7, 8'd60};
    sb.push_back(mk(0, 60));
    sb.push_back(mk(1, 7));
    @(posedge clk);
    #2 req = 4'b0011;
    wait_valid(1'b1);
    @(posedge clk);
    @(posedge clk);
    #2 req = 4'b0010;
    @(negedge clk);
    @(negedge clk);
    chk("early_grant", grant, 0);
    chk("early_valid", bcd_valid, 0);
    @(negedge clk);
    chk("next_grant", grant, 4'b0010);
    wait_valid(1'b1);
    wait_valid(1'b0);
    req = '0;
    do_reset();
    data = {24'd0, 8'd42};
    sb.push_back(mk(0, 42));
    @(posedge clk);
    #2 req = 4'b0001;
    wait_valid(1'b1);
    repeat (2) @(posedge clk);
    #2 data[7:0] = 8'd17;
    wait_valid(1'b0);
    req = '0;
    do_reset();
    data = {8'd255, 8'd0, 16'd0};
    sb.push_back(mk(2, 0));
    @(posedge clk);
    #2 req = 4'b0100;
    wait_valid(1'b1);
    wait_valid(1'b0);
    req = '0;
    sb.push_back(mk(3, 255));
    @(posedge clk);
    #2 req = 4'b1000;
    wait_valid(1'b1);
    wait_valid(1'b0);
    req = '0;
    repeat (5) @(posedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
